tdm_mux_8_to_1: RTL

- Time-division 8:1 multiplexer/serializer; the transmit-side counterpart of the team's 1-to-8 demultiplexer.
- Captures one frame of 8 lane words in parallel, then emits them on one line, one lane per accepted beat.
- Each beat carries the lane index on `sel`, so a downstream 1-to-8 demux driven by (`dout`, `sel`) rebuilds the frame.
- Sits between parallel producer logic and a narrow serial/shared link.

---
 rtl/tdm_mux_8_to_1_pkg.sv | 32 +++
 rtl/tdm_mux_8_to_1_lane_ctr.sv | 33 +++
 rtl/tdm_mux_8_to_1.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/tdm_mux_8_to_1_pkg.sv
// tdm_pkg: shared definitions for the 8:1 time-division multiplexer.
//   LANES / SEL_W : lane count and width of the lane index.
//   MAX_WIDTH     : widest lane word that lane_word() can slice.
//   state_t       : controller states (PAR is only entered when the
//                   TDM_MUX_PARITY_EN macro is defined).
//   lane_word()   : returns lane idx of a frame, right-justified.
package tdm_pkg;

    localparam int LANES     = 8;
    localparam int SEL_W     = 3;
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAR  = 2'd2
    } state_t;

    // The frame is passed zero-extended to the maximum supported width.
    // Bits above the caller's own lane width must be discarded by the
    // caller, because they belong to the next lanes up.
    function automatic logic [MAX_WIDTH-1:0] lane_word(
        input logic [LANES*MAX_WIDTH-1:0] frame,
        input logic [SEL_W-1:0]           idx,
        input int                         width
    );
        logic [LANES*MAX_WIDTH-1:0] shifted;
        shifted = frame >> (int'(idx) * width);
        return shifted[MAX_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/tdm_mux_8_to_1_lane_ctr.sv
// tdm_lane_ctr: 3-bit lane counter for the TDM multiplexer.
//   clk, rst_n : clock, asynchronous active-low reset.
//   clear      : force the count to lane 0 (wins over advance).
//   advance    : step to the next lane; lane 7 wraps to lane 0.
//   lane       : current lane index.
//   last       : high while the current lane is lane 7.
module tdm_lane_ctr
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [SEL_W-1:0] lane,
    output logic             last
);

    logic [SEL_W-1:0] lane_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_reg <= '0;
        end else if (clear) begin
            lane_reg <= '0;
        end else if (advance) begin
            lane_reg <= lane_reg + SEL_W'(1);
        end
    end

    assign lane = lane_reg;
    assign last = (lane_reg == SEL_W'(LANES - 1));

endmodule

// File: rtl/tdm_mux_8_to_1.sv
// tdm_mux_8_to_1: captures an 8-lane frame in parallel and emits it one
// lane per accepted beat, tagging each beat with its lane index.
//   clk, rst_n         : clock, asynchronous active-low reset.
//   in_valid, in_ready : frame handshake (in_ready depends combinationally
//                        on out_ready so a new frame can follow with no bubble).
//   din                : frame, lane k in din[k*WIDTH +: WIDTH].
//   out_valid, out_ready : beat handshake.
//   dout, sel          : current lane word and its lane index.
//   sof, eof           : first / last beat of the frame.
//   par_slot           : parity beat marker.
// Optional build macro TDM_MUX_PARITY_EN: appends a ninth beat carrying the
// XOR of all lane words (sel=7, par_slot=1, eof moves to that beat).
// Without it par_slot is tied low and eof marks lane 7.
module tdm_mux_8_to_1
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1  // must not exceed MAX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] din,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       dout,
    output logic [SEL_W-1:0]       sel,
    output logic                   sof,
    output logic                   eof,
    output logic                   par_slot
);

    state_t                    state_reg, state_next;
    logic [LANES*WIDTH-1:0]    frame_reg;
    logic [LANES*MAX_WIDTH-1:0] frame_ext;
    logic [MAX_WIDTH-1:0]      word_wide;
    logic                      unused_word_hi;
    logic [SEL_W-1:0]          lane;
    logic                      lane_last;
    logic                      accept;
    logic                      ctr_adv;
    logic [WIDTH-1:0]          parity;

    tdm_lane_ctr u_lane_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .advance (ctr_adv),
        .lane    (lane),
        .last    (lane_last)
    );

    // A new frame may be taken while idle, or in the very cycle the final
    // beat of the current frame is consumed.
    always_comb begin
        in_ready = (state_reg == IDLE);
`ifdef TDM_MUX_PARITY_EN
        if (state_reg == PAR && out_ready) begin
            in_ready = 1'b1;
        end
`else
        if (state_reg == SEND && lane_last && out_ready) begin
            in_ready = 1'b1;
        end
`endif
    end

    assign accept = in_valid & in_ready;

    // The frame register only loads on acceptance, so din is ignored for
    // the whole time a frame is being sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_reg <= '0;
        end else if (accept) begin
            frame_reg <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ctr_adv    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    ctr_adv = 1'b1;
                    if (lane_last) begin
`ifdef TDM_MUX_PARITY_EN
                        state_next = PAR;
`else
                        state_next = in_valid ? SEND : IDLE;
`endif
                    end
                end
            end
            PAR: begin
`ifdef TDM_MUX_PARITY_EN
                if (out_ready) begin
                    state_next = in_valid ? SEND : IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_ext                    = '0;
        frame_ext[LANES*WIDTH-1:0]   = frame_reg;
    end

    assign word_wide      = lane_word(frame_ext, lane, WIDTH);
    // Only the low WIDTH bits are this lane; the rest is deliberately dropped.
    assign unused_word_hi = ^word_wide;

`ifdef TDM_MUX_PARITY_EN
    logic [WIDTH-1:0] lane_w [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_w[gi] = frame_reg[gi*WIDTH +: WIDTH];
    end

    always_comb begin
        parity = '0;
        for (int i = 0; i < LANES; i++) begin
            parity = parity ^ lane_w[i];
        end
    end
`else
    assign parity = '0;
`endif

    // Outputs are decoded from registered state only; everything is forced
    // to zero outside an active beat so reset and idle read back as zero.
    always_comb begin
        out_valid = 1'b0;
        dout      = '0;
        sel       = '0;
        sof       = 1'b0;
        eof       = 1'b0;
        par_slot  = 1'b0;
        case (state_reg)
            SEND: begin
                out_valid = 1'b1;
                dout      = word_wide[WIDTH-1:0];
                sel       = lane;
                sof       = (lane == '0);
`ifndef TDM_MUX_PARITY_EN
                eof       = lane_last;
`endif
            end
            PAR: begin
`ifdef TDM_MUX_PARITY_EN
                out_valid = 1'b1;
                dout      = parity;
                sel       = SEL_W'(LANES - 1);
                eof       = 1'b1;
                par_slot  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule
